// File: rtl/uart_pkg.sv
// Shared UART definitions: default word size, baud divider helper and the
// tx arbiter state encoding.
package uart_pkg;

  localparam int UART_WORD_SIZE = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SEND = 2'd1,
    ARB_BUSY = 2'd2
  } arb_state_e;

  // Clock cycles per baud tick; also sizes the transmitter's divider.
  function automatic int baud_limit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request after last_i, wrapping
// modulo NUM_REQ.
module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int IDXW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDXW-1:0]    last_i,
  output logic [IDXW-1:0]    grant_o,
  output logic               any_valid_o
);

  always_comb begin
    int idx;
    idx         = 0;
    grant_o     = '0;
    any_valid_o = 1'b0;
    // Walk from the farthest offset back to the nearest so the closest wins.
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(last_i) + off) % NUM_REQ;
      if (req_i[idx]) begin
        grant_o     = IDXW'(idx);
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NUM_REQ requesters.
// Optional watchdog abort is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WORD_SIZE      = UART_WORD_SIZE,
  parameter int CLOCK_FREQ     = 50000000,
  parameter int BAUD_RATE      = 9600,
  parameter int TIMEOUT_CYCLES = (WORD_SIZE + 4) * (baud_limit(CLOCK_FREQ, BAUD_RATE) + 1),
  localparam int IDXW = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [WORD_SIZE-1:0]           tx_data,
  output logic                           tx_send,
  input  logic                           tx_avbl,
  output logic [IDXW-1:0]                grant_id,
  output logic                           busy,
  output logic                           err_timeout,
  output arb_state_e                     state_dbg
);

  // Handshake: requester i holds req_valid[i] and its word stable until a
  // one-cycle req_ready[i] pulse; the word is latched on that same edge.
  arb_state_e             state_q;
  logic [WORD_SIZE-1:0]   tx_data_q;
  logic                   tx_send_q;
  logic [NUM_REQ-1:0]     req_ready_q;
  logic [IDXW-1:0]        grant_q;
  logic [IDXW-1:0]        last_q;
  logic                   busy_q;
  logic                   first_send_q;

  logic [IDXW-1:0]        pick_idx;
  logic                   pick_any;
  logic [WORD_SIZE-1:0]   word_d;

  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i       (req_valid),
    .last_i      (last_q),
    .grant_o     (pick_idx),
    .any_valid_o (pick_any)
  );

  assign word_d = req_data[int'(pick_idx)*WORD_SIZE +: WORD_SIZE];

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q;
  logic              err_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      tx_data_q    <= '0;
      tx_send_q    <= 1'b0;
      req_ready_q  <= '0;
      grant_q      <= '0;
      last_q       <= IDXW'(NUM_REQ - 1);
      busy_q       <= 1'b0;
      first_send_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      wdog_q       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            tx_data_q    <= word_d;
            grant_q      <= pick_idx;
            last_q       <= pick_idx;
            req_ready_q  <= NUM_REQ'(1) << pick_idx;
            tx_send_q    <= 1'b1;
            busy_q       <= 1'b1;
            first_send_q <= 1'b1;
            state_q      <= ARB_SEND;
`ifdef UART_ARB_TIMEOUT_EN
            wdog_q       <= '0;
`endif
          end
        end
        ARB_SEND: begin
          first_send_q <= 1'b0;
          // An avbl pulse in the first SEND cycle was raised while tx_send was still low.
          if (tx_avbl && !first_send_q) begin
            tx_send_q <= 1'b0;
            state_q   <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (tx_avbl) begin
            busy_q  <= 1'b0;
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
`ifdef UART_ARB_TIMEOUT_EN
      if (state_q != ARB_IDLE) begin
        wdog_q <= wdog_q + 1'b1;
        if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
          tx_send_q <= 1'b0;
          busy_q    <= 1'b0;
          err_q     <= 1'b1;
          state_q   <= ARB_IDLE;
        end
      end
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_send   = tx_send_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

`ifdef UART_ARB_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign err_timeout           = 1'b0;
`endif

endmodule
